// File: rtl/key_event_generator.sv
// Per-key press / release / auto-repeat pulse generator with a long-hold level.
// Two identical, independent FSMs share a free-running millisecond tick.
module key_event_generator #(
    parameter int CLK_FREQ_HZ    = 50_000_000,
    parameter int LONG_MS        = 1000,
    parameter int REPEAT_MS      = 200,
    parameter bit KEY_ACTIVE_LOW = 1'b1
) (
    input  logic       sysClk,
    input  logic       sysRst,
    input  logic [1:0] stableKey,
    output logic [1:0] pressPulse,
    output logic [1:0] releasePulse,
    output logic [1:0] repeatPulse,
    output logic [1:0] longHold
);

    localparam int DIV = (CLK_FREQ_HZ / 1000 < 1) ? 1 : CLK_FREQ_HZ / 1000;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int HW  = $clog2(LONG_MS + 1);
    localparam int RW  = $clog2(REPEAT_MS + 1);

    localparam logic [PW-1:0] PRE_LAST  = PW'(DIV - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_MS);
    localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_MS);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHORT = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    function automatic logic [HW-1:0] sat_inc_hold(input logic [HW-1:0] v);
        return (v == {HW{1'b1}}) ? v : v + HW'(1);
    endfunction

    function automatic logic [RW-1:0] sat_inc_rep(input logic [RW-1:0] v);
        return (v == {RW{1'b1}}) ? v : v + RW'(1);
    endfunction

    logic [PW-1:0] prescaler_q, prescaler_d;
    logic          ms_tick;
    logic [1:0]    act;
    logic [1:0]    prev_act_q;
    logic [1:0]    state_q [2];
    logic [1:0]    state_d [2];
    logic [HW-1:0] hold_cnt_q [2];
    logic [HW-1:0] hold_cnt_d [2];
    logic [RW-1:0] rep_cnt_q [2];
    logic [RW-1:0] rep_cnt_d [2];
    logic [1:0]    press_q, press_d;
    logic [1:0]    release_q, release_d;
    logic [1:0]    repeat_q, repeat_d;
    logic [1:0]    long_q, long_d;

    assign ms_tick     = (prescaler_q == PRE_LAST);
    assign prescaler_d = ms_tick ? '0 : prescaler_q + PW'(1);
    assign act         = KEY_ACTIVE_LOW ? ~stableKey : stableKey;

    // Release is tested before the tick so it always wins over a due repeat.
    always_comb begin
        press_d   = '0;
        release_d = '0;
        repeat_d  = '0;
        long_d    = long_q;
        for (int i = 0; i < 2; i++) begin
            state_d[i]    = state_q[i];
            hold_cnt_d[i] = hold_cnt_q[i];
            rep_cnt_d[i]  = rep_cnt_q[i];
            case (state_q[i])
                ST_IDLE: begin
                    if (act[i] && !prev_act_q[i]) begin
                        press_d[i]    = 1'b1;
                        hold_cnt_d[i] = '0;
                        state_d[i]    = ST_SHORT;
                    end
                end
                ST_SHORT: begin
                    if (!act[i]) begin
                        release_d[i] = 1'b1;
                        state_d[i]   = ST_IDLE;
                    end else if (ms_tick) begin
                        hold_cnt_d[i] = sat_inc_hold(hold_cnt_q[i]);
                        if (hold_cnt_d[i] == HOLD_LAST) begin
                            repeat_d[i]  = 1'b1;
                            long_d[i]    = 1'b1;
                            rep_cnt_d[i] = '0;
                            state_d[i]   = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!act[i]) begin
                        release_d[i] = 1'b1;
                        long_d[i]    = 1'b0;
                        state_d[i]   = ST_IDLE;
                    end else if (ms_tick) begin
                        rep_cnt_d[i] = sat_inc_rep(rep_cnt_q[i]);
                        if (rep_cnt_d[i] == REP_LAST) begin
                            repeat_d[i]  = 1'b1;
                            rep_cnt_d[i] = '0;
                        end
                    end
                end
                default: begin
                    state_d[i] = ST_IDLE;
                    long_d[i]  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge sysClk or negedge sysRst) begin
        if (!sysRst) begin
            prescaler_q <= '0;
            prev_act_q  <= '0;
            press_q     <= '0;
            release_q   <= '0;
            repeat_q    <= '0;
            long_q      <= '0;
            for (int i = 0; i < 2; i++) begin
                state_q[i]    <= ST_IDLE;
                hold_cnt_q[i] <= '0;
                rep_cnt_q[i]  <= '0;
            end
        end else begin
            prescaler_q <= prescaler_d;
            prev_act_q  <= act;
            press_q     <= press_d;
            release_q   <= release_d;
            repeat_q    <= repeat_d;
            long_q      <= long_d;
            for (int i = 0; i < 2; i++) begin
                state_q[i]    <= state_d[i];
                hold_cnt_q[i] <= hold_cnt_d[i];
                rep_cnt_q[i]  <= rep_cnt_d[i];
            end
        end
    end

    assign pressPulse   = press_q;
    assign releasePulse = release_q;
    assign repeatPulse  = repeat_q;
    assign longHold     = long_q;

endmodule

// File: tb/tb_key_event_generator.sv
// Bench for key_event_generator: directed scenarios plus random key activity,
// scored against a millisecond-count reference model through an expectation queue.
module tb_key_event_generator;

    localparam int CLK_HZ = 10_000;
    localparam int LONG   = 5;
    localparam int REP    = 2;
    localparam int DIV    = CLK_HZ / 1000;

    logic       sysClk    = 1'b0;
    logic       sysRst    = 1'b0;
    logic [1:0] stableKey = 2'b11;
    logic [1:0] pressPulse, releasePulse, repeatPulse, longHold;

    key_event_generator #(
        .CLK_FREQ_HZ   (CLK_HZ),
        .LONG_MS       (LONG),
        .REPEAT_MS     (REP),
        .KEY_ACTIVE_LOW(1'b1)
    ) dut (
        .sysClk      (sysClk),
        .sysRst      (sysRst),
        .stableKey   (stableKey),
        .pressPulse  (pressPulse),
        .releasePulse(releasePulse),
        .repeatPulse (repeatPulse),
        .longHold    (longHold)
    );

    always #5 sysClk = ~sysClk;

    typedef struct packed {
        logic [1:0] press;
        logic [1:0] rel;
        logic [1:0] rpt;
        logic [1:0] lng;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   fails  = 0;

    // Reference model: a key is "active" from press until release; ms elapsed
    // since the press decide repeats (LONG, LONG+REP, LONG+2*REP, ...).
    int m_pcnt = 0;
    bit m_active [2];
    bit m_prev   [2];
    int m_ticks  [2];

    task automatic check(input string name, input logic [1:0] got, input logic [1:0] want);
        checks++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s at %0t: got %b, expected %b", name, $time, got, want);
        end
    endtask

    always @(posedge sysClk) begin : model
        exp_t       e;
        logic [1:0] a;
        bit         tick;
        e = '0;
        a = ~stableKey;
        if (!sysRst) begin
            m_pcnt = 0;
            for (int i = 0; i < 2; i++) begin
                m_active[i] = 1'b0;
                m_prev[i]   = 1'b0;
                m_ticks[i]  = 0;
            end
        end else begin
            tick   = (m_pcnt == DIV - 1);
            m_pcnt = (m_pcnt + 1) % DIV;
            for (int i = 0; i < 2; i++) begin
                if (!m_active[i]) begin
                    if (a[i] && !m_prev[i]) begin
                        e.press[i]  = 1'b1;
                        m_active[i] = 1'b1;
                        m_ticks[i]  = 0;
                    end
                end else if (!a[i]) begin
                    e.rel[i]    = 1'b1;
                    m_active[i] = 1'b0;
                end else if (tick) begin
                    m_ticks[i]++;
                    if (m_ticks[i] >= LONG && (m_ticks[i] - LONG) % REP == 0)
                        e.rpt[i] = 1'b1;
                end
                e.lng[i]  = m_active[i] && (m_ticks[i] >= LONG);
                m_prev[i] = a[i];
            end
        end
        exp_q.push_back(e);
    end

    always @(negedge sysClk) begin : monitor
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL scoreboard_empty at %0t: got no expectation, expected one per cycle", $time);
        end else begin
            e = exp_q.pop_front();
            check("sb_pressPulse",   pressPulse,   e.press);
            check("sb_releasePulse", releasePulse, e.rel);
            check("sb_repeatPulse",  repeatPulse,  e.rpt);
            check("sb_longHold",     longHold,     e.lng);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int g;
        int dur [2];
        bit found;

        // Reset, idle keys
        sysRst    = 1'b0;
        stableKey = 2'b11;
        repeat (3) @(negedge sysClk);
        check("reset_long", longHold, 2'b00);
        sysRst = 1'b1;
        repeat (100) @(negedge sysClk);

        // Short press on key0
        stableKey[0] = 1'b0;
        @(negedge sysClk);
        check("t2_press", pressPulse, 2'b01);
        repeat (19) @(negedge sysClk);
        stableKey[0] = 1'b1;
        @(negedge sysClk);
        check("t2_release", releasePulse, 2'b01);
        repeat (10) @(negedge sysClk);

        // Long hold on key1: first repeat 41..50 cycles after the press pulse
        stableKey[1] = 1'b0;
        @(negedge sysClk);
        check("t3_press", pressPulse, 2'b10);
        g = 0;
        do begin
            @(negedge sysClk);
            g++;
        end while (!repeatPulse[1] && g < 60);
        checks++;
        if (g < 41 || g > 50) begin
            fails++;
            $display("FAIL t3_first_repeat_gap: got %0d cycles, expected 41..50", g);
        end
        check("t3_long_rise", longHold, 2'b10);
        repeat (119 - g) @(negedge sysClk);
        stableKey[1] = 1'b1;
        @(negedge sysClk);
        check("t3_release", releasePulse, 2'b10);
        check("t3_long_fall", longHold, 2'b00);
        repeat (10) @(negedge sysClk);

        // Both keys together, key0 released early
        stableKey = 2'b00;
        @(negedge sysClk);
        check("t4_press_both", pressPulse, 2'b11);
        repeat (14) @(negedge sysClk);
        stableKey[0] = 1'b1;
        @(negedge sysClk);
        check("t4_release_key0", releasePulse, 2'b01);
        repeat (60) @(negedge sysClk);
        check("t4_key1_long", longHold, 2'b10);
        stableKey[1] = 1'b1;
        repeat (10) @(negedge sysClk);

        // Asynchronous reset in the middle of HOLD
        stableKey[1] = 1'b0;
        repeat (70) @(negedge sysClk);
        check("t5_pre_reset_long", longHold, 2'b10);
        #2 sysRst = 1'b0;
        #1;
        check("t5_async_press",   pressPulse,   2'b00);
        check("t5_async_release", releasePulse, 2'b00);
        check("t5_async_repeat",  repeatPulse,  2'b00);
        check("t5_async_long",    longHold,     2'b00);
        repeat (3) @(negedge sysClk);
        sysRst = 1'b1;
        @(negedge sysClk);
        check("t5_press_after_reset", pressPulse, 2'b10);
        repeat (70) @(negedge sysClk);
        stableKey[1] = 1'b1;
        repeat (10) @(negedge sysClk);

        // Release exactly when a repeat is due
        stableKey[1] = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge sysClk);
            if (m_active[1] && m_pcnt == DIV - 1 && m_ticks[1] + 1 > LONG
                && (m_ticks[1] + 1 - LONG) % REP == 0)
                found = 1'b1;
        end
        if (!found) begin
            checks++;
            fails++;
            $display("FAIL t6_due_search: got no due repeat slot, expected one within 200 cycles");
        end else begin
            stableKey[1] = 1'b1;
            @(negedge sysClk);
            check("t6_release_wins", releasePulse, 2'b10);
            check("t6_no_repeat",    repeatPulse,  2'b00);
        end
        repeat (10) @(negedge sysClk);

        // Random key activity
        dur[0] = 0;
        dur[1] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (dur[k] == 0) begin
                    stableKey[k] = 1'($urandom_range(0, 1));
                    dur[k]       = $urandom_range(1, 90);
                end
                dur[k]--;
            end
            @(negedge sysClk);
        end

        stableKey = 2'b11;
        repeat (5) @(negedge sysClk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
